// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, machine word, arbiter grant states.
// Latency: none (types only).
// Backpressure: none (types only).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Status reported by the RAM model/controller each cycle.
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    // Which requester currently owns the RAM port.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_DATA  = 2'b01,
        ARB_INSTR = 2'b10
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between icache fetches and dcache reads/writes, data-first with anti-starvation.
// Latency: grant registered one cycle after a request is seen idle; wait drops in the RAM ACCESS cycle.
// Backpressure: the granted side sees wait=1 until ACCESS; the other side waits; one idle bubble per word.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    // Consecutive data words allowed while a fetch is pending; keep it even.
    parameter int STARVE_LIMIT = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    // icache side
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    // dcache side
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    // RAM side
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    // sticky RAM error
    output logic      bus_err
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    logic [CNT_W-1:0] starve_cnt;
    logic             d_req;

    // Grant register, starvation counter and sticky error flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= ARB_IDLE;
            starve_cnt <= '0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    // A starved fetch beats any data request; otherwise data goes first.
                    if (iREN && (starve_cnt == CNT_MAX)) begin
                        state <= ARB_INSTR;
                    end else if (d_req) begin
                        state <= ARB_DATA;
                    end else if (iREN) begin
                        state <= ARB_INSTR;
                    end
                end
                ARB_DATA: begin
                    if (ramstate == ERROR) begin
                        bus_err <= 1'b1;
                    end
                    // A withdrawn request releases the port without counting a word.
                    if (!d_req) begin
                        state <= ARB_IDLE;
                    end else if (ramstate == ACCESS) begin
                        state <= ARB_IDLE;
                        if (iREN && (starve_cnt != CNT_MAX)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                ARB_INSTR: begin
                    if (ramstate == ERROR) begin
                        bus_err <= 1'b1;
                    end
                    if (!iREN) begin
                        state <= ARB_IDLE;
                    end else if (ramstate == ACCESS) begin
                        state      <= ARB_IDLE;
                        starve_cnt <= '0;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // RAM request mux and per-requester wait/load steering from the current grant.
    always_comb begin
        d_req    = dREN | dWEN;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        case (state)
            ARB_DATA: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                // A write takes precedence when both strobes are up.
                ramREN   = dREN & ~dWEN;
                dwait    = (ramstate != ACCESS);
                dload    = ramload;
            end
            ARB_INSTR: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                iwait   = (ramstate != ACCESS);
                iload   = ramload;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: CLK in 1 system clock; nRST in 1 asynchronous active-low reset.
REQ-002 SHALL have icache-side ports: iREN in 1 fetch request; iaddr in 32 fetch address; iwait out 1 fetch stall; iload out 32 fetch data.
REQ-003 SHALL have dcache-side ports: dREN in 1 read request; dWEN in 1 write request; daddr in 32 address; dstore in 32 write data; dwait out 1 stall; dload out 32 read data.
REQ-004 SHALL have RAM-side ports: ramREN out 1; ramWEN out 1; ramaddr out 32; ramstore out 32; ramload in 32; ramstate in 2 (ramstate_t).
REQ-005 SHALL have port bus_err out 1, a sticky RAM error flag.
REQ-006 SHALL use parameter STARVE_LIMIT, default 4, meaning the maximum consecutive data words granted while iREN is pending; it SHALL be even.

Function
REQ-007 SHALL implement FSM states ARB_IDLE, ARB_DATA and ARB_INSTR, with a registered grant.
REQ-008 ARB_IDLE SHALL drive no RAM request and SHALL hold iwait=1 and dwait=1.
REQ-009 ARB_IDLE priority SHALL be: if iREN and starve_cnt==STARVE_LIMIT, go to ARB_INSTR; else if dREN|dWEN, go to ARB_DATA; else if iREN, go to ARB_INSTR; else stay.
REQ-010 In ARB_DATA, ramaddr SHALL equal daddr, ramstore SHALL equal dstore, and ramWEN SHALL equal dWEN.
REQ-011 In ARB_DATA, ramREN SHALL equal dREN&~dWEN, so dWEN wins if both are asserted.
REQ-012 In ARB_DATA, dwait SHALL be ~(ramstate==ACCESS), and iwait SHALL be 1.
REQ-013 In ARB_INSTR, ramaddr SHALL equal iaddr, ramREN SHALL be 1, ramWEN SHALL be 0, ramstore SHALL be 0, iwait SHALL be ~(ramstate==ACCESS), and dwait SHALL be 1.
REQ-014 Read data SHALL pass through: dload=ramload in ARB_DATA, else 0; iload=ramload in ARB_INSTR, else 0.
REQ-015 On ramstate==ACCESS in ARB_DATA or ARB_INSTR, the next state SHALL be ARB_IDLE, giving exactly one idle bubble per word.
REQ-016 If the granted requester deasserts before ACCESS, the next state SHALL be ARB_IDLE with no completion counted.
REQ-017 Completion of a data word SHALL set starve_cnt to min(starve_cnt+1, STARVE_LIMIT) when iREN=1, and leave it unchanged when iREN=0.
REQ-018 Completion of an instruction word SHALL clear starve_cnt; starve_cnt width SHALL be $clog2(STARVE_LIMIT+1).
REQ-019 ramstate FREE or BUSY SHALL hold the current grant with wait asserted.
REQ-020 ramstate ERROR SHALL hold the grant with wait asserted and set bus_err=1 until reset.
REQ-021 Request-to-RAM latency SHALL be one cycle from request seen in ARB_IDLE; the requester's wait drops in the ACCESS cycle.

Reset
REQ-022 nRST low SHALL asynchronously force state ARB_IDLE, starve_cnt=0 and bus_err=0.
REQ-023 During reset, outputs SHALL be: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0, dload=0.
REQ-024 Reset mid-transaction SHALL abandon the word; no completion is counted and no grant persists.

Structure
REQ-025 ramstate_t (FREE, BUSY, ACCESS, ERROR) and word_t SHALL come from cpu_types_pkg.
REQ-026 The arbiter state enum SHALL be defined in cpu_types_pkg as arb_state_t.
REQ-027 The design SHALL be a single module with one always_ff and one always_comb block; no sub-module.

Verification
REQ-028 Scenario: dREN=1 with daddr=0x100, iREN=0, RAM ACCESS after 2 BUSY cycles -> ramREN=1 and ramaddr=0x100 from cycle 1; dwait=0 only on the ACCESS cycle; dload=ramload.
REQ-029 Scenario: dREN=1 and iREN=1 held continuously, each RAM word taking 1 cycle -> 4 data grants, then 1 instruction grant, then data again; starve_cnt returns to 0 after the instruction word.
REQ-030 Scenario: dWEN=1 and dREN=1 with daddr=0x3100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
REQ-031 Scenario: ramstate=ERROR during an ARB_INSTR grant -> iwait=1 held and bus_err=1; bus_err stays 1 after ramstate returns to FREE, until nRST pulses.
REQ-032 Scenario: nRST asserted while in ARB_DATA with BUSY -> ramREN=0, dwait=1, and state ARB_IDLE immediately, without waiting for a clock edge.
REQ-033 Scenario: iREN drops before ACCESS in ARB_INSTR -> ARB_IDLE next cycle, starve_cnt unchanged, no iwait=0 pulse.
